// File: rtl/instruction_register.sv
// Purpose : multicycle-CPU instruction register with decoded field views of the held word.
// Latency : one Clk edge from IRWrite=1 to updated outputs; every output is a slice of IR_q.
// Backpres: none; IRWrite is a plain load enable and the held word is stable until the next load.
//
// Ports:
//   Clk, Rst     - rising-edge clock, synchronous active-high reset (Rst wins over IRWrite)
//   Instruction  - 32-bit word from memory, captured when IRWrite=1
//   IRWrite      - load enable
//   Opcode/R1/R2/R3/Imm/Shamt/Funct/Target - overlapping field slices of IR_q
//   ImmSext/ImmZext - Imm sign- / zero-extended to 32 bits
//   IsRType      - Opcode == 0
//   Valid        - at least one load since reset
//   IR           - full stored word
//   PrevIR       - (only with IR_PREV_EN) word that IR held before the most recent load
//
// Build option: define IR_PREV_EN to add the PrevIR shadow register and port.
module instruction_register #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        IRWrite,
  output logic [5:0]  Opcode,
  output logic [4:0]  R1,
  output logic [4:0]  R2,
  output logic [4:0]  R3,
  output logic [15:0] Imm,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [25:0] Target,
  output logic [31:0] ImmSext,
  output logic [31:0] ImmZext,
  output logic        IsRType,
  output logic        Valid,
  output logic [31:0] IR
`ifdef IR_PREV_EN
  ,
  output logic [31:0] PrevIR
`endif
);

  logic [31:0] IR_q;
  logic        valid_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      IR_q    <= RESET_INSTR;
      valid_q <= 1'b0;
    end else if (IRWrite) begin
      IR_q    <= Instruction;
      valid_q <= 1'b1;
    end
  end

`ifdef IR_PREV_EN
  logic [31:0] prev_q;

  // Shadow copy takes the outgoing word on the same edge IR_q takes the new one.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      prev_q <= RESET_INSTR;
    end else if (IRWrite) begin
      prev_q <= IR_q;
    end
  end

  assign PrevIR = prev_q;
`endif

  // All decode is from the stored word only, so Instruction never reaches an output combinationally.
  assign IR      = IR_q;
  assign Opcode  = IR_q[31:26];
  assign R1      = IR_q[25:21];
  assign R2      = IR_q[20:16];
  assign R3      = IR_q[15:11];
  assign Imm     = IR_q[15:0];
  assign Shamt   = IR_q[10:6];
  assign Funct   = IR_q[5:0];
  assign Target  = IR_q[25:0];
  assign ImmSext = {{16{IR_q[15]}}, IR_q[15:0]};
  assign ImmZext = {16'h0000, IR_q[15:0]};
  assign IsRType = (IR_q[31:26] == 6'b000000);
  assign Valid   = valid_q;

endmodule

// File: tb/tb_instruction_register.sv
module tb_instruction_register;

  logic        Clk;
  logic        Rst;
  logic [31:0] Instruction;
  logic        IRWrite;
  logic [5:0]  Opcode;
  logic [4:0]  R1;
  logic [4:0]  R2;
  logic [4:0]  R3;
  logic [15:0] Imm;
  logic [4:0]  Shamt;
  logic [5:0]  Funct;
  logic [25:0] Target;
  logic [31:0] ImmSext;
  logic [31:0] ImmZext;
  logic        IsRType;
  logic        Valid;
  logic [31:0] IR;
`ifdef IR_PREV_EN
  logic [31:0] PrevIR;
`endif

  int pass_cnt;
  int total_cnt;

  instruction_register #(.RESET_INSTR(32'h0000_0000)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Instruction (Instruction),
    .IRWrite     (IRWrite),
    .Opcode      (Opcode),
    .R1          (R1),
    .R2          (R2),
    .R3          (R3),
    .Imm         (Imm),
    .Shamt       (Shamt),
    .Funct       (Funct),
    .Target      (Target),
    .ImmSext     (ImmSext),
    .ImmZext     (ImmZext),
    .IsRType     (IsRType),
    .Valid       (Valid),
    .IR          (IR)
`ifdef IR_PREV_EN
    ,
    .PrevIR      (PrevIR)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Expected field values for a held word w, built from the field layout.
  task automatic check_fields(input string tag, input logic [31:0] w, input logic v);
    check({tag, ".IR"},      IR,                       w);
    check({tag, ".Opcode"},  {26'd0, Opcode},          {26'd0, w[31:26]});
    check({tag, ".R1"},      {27'd0, R1},              {27'd0, w[25:21]});
    check({tag, ".R2"},      {27'd0, R2},              {27'd0, w[20:16]});
    check({tag, ".R3"},      {27'd0, R3},              {27'd0, w[15:11]});
    check({tag, ".Imm"},     {16'd0, Imm},             {16'd0, w[15:0]});
    check({tag, ".Shamt"},   {27'd0, Shamt},           {27'd0, w[10:6]});
    check({tag, ".Funct"},   {26'd0, Funct},           {26'd0, w[5:0]});
    check({tag, ".Target"},  {6'd0, Target},           {6'd0, w[25:0]});
    check({tag, ".ImmSext"}, ImmSext,                  {{16{w[15]}}, w[15:0]});
    check({tag, ".ImmZext"}, ImmZext,                  {16'd0, w[15:0]});
    check({tag, ".IsRType"}, {31'd0, IsRType},         {31'd0, (w[31:26] == 6'd0)});
    check({tag, ".Valid"},   {31'd0, Valid},           {31'd0, v});
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] prev_w;
    logic [31:0] held;

    pass_cnt    = 0;
    total_cnt   = 0;
    Rst         = 1'b1;
    IRWrite     = 1'b1;
    Instruction = 32'hFFFF_FFFF;

    // Reset dominates a pending load of all-ones.
    step();
    step();
    check("rst.IR",      IR,               32'h0);
    check("rst.Opcode",  {26'd0, Opcode},  32'h0);
    check("rst.R1",      {27'd0, R1},      32'h0);
    check("rst.R2",      {27'd0, R2},      32'h0);
    check("rst.R3",      {27'd0, R3},      32'h0);
    check("rst.Imm",     {16'd0, Imm},     32'h0);
    check("rst.Shamt",   {27'd0, Shamt},   32'h0);
    check("rst.Funct",   {26'd0, Funct},   32'h0);
    check("rst.Target",  {6'd0, Target},   32'h0);
    check("rst.ImmSext", ImmSext,          32'h0);
    check("rst.ImmZext", ImmZext,          32'h0);
    check("rst.IsRType", {31'd0, IsRType}, 32'h1);
    check("rst.Valid",   {31'd0, Valid},   32'h0);
`ifdef IR_PREV_EN
    check("rst.PrevIR",  PrevIR,           32'h0);
`endif

    // No load enable: random words must be ignored.
    Rst     = 1'b0;
    IRWrite = 1'b0;
    for (int i = 0; i < 40; i++) begin
      Instruction = $urandom;
      step();
      check("idle.IR",    IR,             32'h0);
      check("idle.Valid", {31'd0, Valid}, 32'h0);
    end

    // I-type load word, negative immediate.
    IRWrite     = 1'b1;
    Instruction = 32'h8C22_FFF0;
    step();
    check("lw.Opcode",  {26'd0, Opcode},  32'h23);
    check("lw.R1",      {27'd0, R1},      32'h1);
    check("lw.R2",      {27'd0, R2},      32'h2);
    check("lw.R3",      {27'd0, R3},      32'h1F);
    check("lw.Imm",     {16'd0, Imm},     32'hFFF0);
    check("lw.Shamt",   {27'd0, Shamt},   32'h1F);
    check("lw.Funct",   {26'd0, Funct},   32'h30);
    check("lw.Target",  {6'd0, Target},   32'h022_FFF0);
    check("lw.ImmSext", ImmSext,          32'hFFFF_FFF0);
    check("lw.ImmZext", ImmZext,          32'h0000_FFF0);
    check("lw.IsRType", {31'd0, IsRType}, 32'h0);
    check("lw.Valid",   {31'd0, Valid},   32'h1);
    check("lw.IR",      IR,               32'h8C22_FFF0);
`ifdef IR_PREV_EN
    check("lw.PrevIR",  PrevIR,           32'h0);
`endif

    // R-type add.
    Instruction = 32'h0043_2020;
    step();
    check("add.Opcode",  {26'd0, Opcode},  32'h0);
    check("add.R1",      {27'd0, R1},      32'h2);
    check("add.R2",      {27'd0, R2},      32'h3);
    check("add.R3",      {27'd0, R3},      32'h4);
    check("add.Shamt",   {27'd0, Shamt},   32'h0);
    check("add.Funct",   {26'd0, Funct},   32'h20);
    check("add.IsRType", {31'd0, IsRType}, 32'h1);
    check("add.ImmSext", ImmSext,          32'h0000_2020);
`ifdef IR_PREV_EN
    check("add.PrevIR",  PrevIR,           32'h8C22_FFF0);
`endif

    // Hold: new word on the bus without IRWrite.
    IRWrite     = 1'b0;
    Instruction = 32'hDEAD_BEEF;
    step();
    step();
    check("hold.IR",      IR,               32'h0043_2020);
    check("hold.Funct",   {26'd0, Funct},   32'h20);
    check("hold.IsRType", {31'd0, IsRType}, 32'h1);
    check("hold.Valid",   {31'd0, Valid},   32'h1);
`ifdef IR_PREV_EN
    check("hold.PrevIR",  PrevIR,           32'h8C22_FFF0);
`endif

    // Back-to-back loads: each cycle reflects the word of the previous edge.
    held    = 32'h0043_2020;
    IRWrite = 1'b1;
    for (int i = 0; i < 40; i++) begin
      w           = $urandom;
      Instruction = w;
      prev_w      = held;
      step();
      check_fields("stream", w, 1'b1);
`ifdef IR_PREV_EN
      check("stream.PrevIR", PrevIR, prev_w);
`endif
      held = w;
    end

    // Reset together with a load discards the pending word.
    Rst         = 1'b1;
    IRWrite     = 1'b1;
    Instruction = 32'h1234_5678;
    step();
    check("rstld.IR",    IR,             32'h0);
    check("rstld.Valid", {31'd0, Valid}, 32'h0);
`ifdef IR_PREV_EN
    check("rstld.PrevIR", PrevIR,        32'h0);
`endif

    // Load A then B after reset.
    Rst         = 1'b0;
    Instruction = 32'hAAAA_0001;
    step();
    Instruction = 32'h0BBB_8002;
    step();
    check_fields("ab", 32'h0BBB_8002, 1'b1);
    check("ab.ImmSext.hand", ImmSext, 32'hFFFF_8002);
`ifdef IR_PREV_EN
    check("ab.PrevIR",   PrevIR,         32'hAAAA_0001);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
